// File: rtl/render_sequencer_if.sv
// Drawer-side bus of the render sequencer: the rectangle being presented,
// the load/go strobes that steer the drawer, its completion flag and the
// pixel write enable forwarded to the VGA adapter.
interface render_sequencer_if;
    logic [7:0] rx;
    logic [6:0] ry;
    logic [4:0] rw;
    logic [4:0] rh;
    logic [2:0] rc;
    logic       drw_load;
    logic       drw_go;
    logic       drw_done;
    logic       plot;

    // Sequencer side: presents rectangles, consumes completion
    modport master (
        output rx, ry, rw, rh, rc, drw_load, drw_go, plot,
        input  drw_done
    );

    // Drawer side: consumes rectangles, reports completion
    modport slave (
        input  rx, ry, rw, rh, rc, drw_load, drw_go, plot,
        output drw_done
    );
endinterface

// File: rtl/render_sequencer.sv
// Frame render sequencer. On each frame_tick it snapshots the object table,
// erases every object's previously drawn rectangle with the background
// colour, then draws every enabled object at its snapshotted position,
// handing one rectangle at a time to an external rectangle drawer.
module render_sequencer #(
    parameter int         NUM_OBJ  = 4,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [8*NUM_OBJ-1:0]   obj_x,
    input  logic [7*NUM_OBJ-1:0]   obj_y,
    input  logic [5*NUM_OBJ-1:0]   obj_w,
    input  logic [5*NUM_OBJ-1:0]   obj_h,
    input  logic [3*NUM_OBJ-1:0]   obj_c,
    input  logic [NUM_OBJ-1:0]     obj_valid,
    render_sequencer_if.master     drw,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int SLOT_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_OBJ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;
    typedef enum logic       {ERASE, DRAW} phase_t;

    state_t              state_reg, state_next;
    phase_t              phase_reg, phase_next;
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic                run_first_reg, run_first_next;
    logic                busy_reg, busy_next;
    logic                frame_done_reg, frame_done_next;
    logic                overrun_reg, overrun_next;

    // Control strobes from the FSM to the object storage
    logic snap_en;
    logic shadow_wr;
    logic shadow_clr;

    // Unpacked views of the packed object inputs
    logic [7:0] in_x [NUM_OBJ];
    logic [6:0] in_y [NUM_OBJ];
    logic [4:0] in_w [NUM_OBJ];
    logic [4:0] in_h [NUM_OBJ];
    logic [2:0] in_c [NUM_OBJ];

    // Per-frame snapshot of the object table
    logic [7:0]         snap_x [NUM_OBJ];
    logic [6:0]         snap_y [NUM_OBJ];
    logic [4:0]         snap_w [NUM_OBJ];
    logic [4:0]         snap_h [NUM_OBJ];
    logic [2:0]         snap_c [NUM_OBJ];
    logic [NUM_OBJ-1:0] snap_valid;

    // Last rectangle actually drawn per slot, used by the erase pass
    logic [7:0]         shd_x [NUM_OBJ];
    logic [6:0]         shd_y [NUM_OBJ];
    logic [4:0]         shd_w [NUM_OBJ];
    logic [4:0]         shd_h [NUM_OBJ];
    logic [NUM_OBJ-1:0] shd_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OBJ; gi++) begin : g_unpack
            assign in_x[gi] = obj_x[gi*8 +: 8];
            assign in_y[gi] = obj_y[gi*7 +: 7];
            assign in_w[gi] = obj_w[gi*5 +: 5];
            assign in_h[gi] = obj_h[gi*5 +: 5];
            assign in_c[gi] = obj_c[gi*3 +: 3];
        end

        for (gi = 0; gi < NUM_OBJ; gi++) begin : g_snap
            // Capture the whole object table once, when a frame starts
            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_x[gi]     <= '0;
                    snap_y[gi]     <= '0;
                    snap_w[gi]     <= '0;
                    snap_h[gi]     <= '0;
                    snap_c[gi]     <= '0;
                    snap_valid[gi] <= 1'b0;
                end else if (snap_en) begin
                    snap_x[gi]     <= in_x[gi];
                    snap_y[gi]     <= in_y[gi];
                    snap_w[gi]     <= in_w[gi];
                    snap_h[gi]     <= in_h[gi];
                    snap_c[gi]     <= in_c[gi];
                    snap_valid[gi] <= obj_valid[gi];
                end
            end
        end
    endgenerate

    // Remember what was drawn for each slot so the next frame can erase it
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                shd_x[i] <= '0;
                shd_y[i] <= '0;
                shd_w[i] <= '0;
                shd_h[i] <= '0;
            end
            shd_valid <= '0;
        end else if (shadow_wr) begin
            shd_x[slot_reg]     <= snap_x[slot_reg];
            shd_y[slot_reg]     <= snap_y[slot_reg];
            shd_w[slot_reg]     <= snap_w[slot_reg];
            shd_h[slot_reg]     <= snap_h[slot_reg];
            shd_valid[slot_reg] <= 1'b1;
        end else if (shadow_clr) begin
            shd_valid[slot_reg] <= 1'b0;
        end
    end

    // Rectangle source for the current slot: shadow while erasing,
    // snapshot while drawing. Neither store changes during LOAD/RUN, so
    // the presented rectangle is stable for the whole drawer transaction.
    logic [7:0] src_x;
    logic [6:0] src_y;
    logic [4:0] src_w;
    logic [4:0] src_h;
    logic [2:0] src_c;
    logic       src_ok;
    logic       eligible;
    logic       presenting;

    assign src_x    = (phase_reg == ERASE) ? shd_x[slot_reg] : snap_x[slot_reg];
    assign src_y    = (phase_reg == ERASE) ? shd_y[slot_reg] : snap_y[slot_reg];
    assign src_w    = (phase_reg == ERASE) ? shd_w[slot_reg] : snap_w[slot_reg];
    assign src_h    = (phase_reg == ERASE) ? shd_h[slot_reg] : snap_h[slot_reg];
    assign src_c    = (phase_reg == ERASE) ? BG_COLOR        : snap_c[slot_reg];
    assign src_ok   = (phase_reg == ERASE) ? shd_valid[slot_reg] : snap_valid[slot_reg];
    assign eligible = src_ok && (src_w != 5'd0) && (src_h != 5'd0);

    // State register and registered status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_reg      <= ERASE;
            slot_reg       <= '0;
            run_first_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            slot_reg       <= slot_next;
            run_first_reg  <= run_first_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next-state logic: walk slots through ERASE then DRAW, one drawer
    // transaction per eligible slot, one cycle per skipped slot
    always_comb begin
        logic advance;
        state_next      = state_reg;
        phase_next      = phase_reg;
        slot_next       = slot_reg;
        run_first_next  = 1'b0;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;
        overrun_next    = frame_tick && (state_reg != IDLE);
        snap_en         = 1'b0;
        shadow_wr       = 1'b0;
        shadow_clr      = 1'b0;
        advance         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (frame_tick) begin
                    snap_en    = 1'b1;
                    phase_next = ERASE;
                    slot_next  = '0;
                    busy_next  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (eligible) begin
                    state_next     = RUN;
                    run_first_next = 1'b1;
                end else begin
                    // Skipped slot; a DRAW slot that is not drawn leaves
                    // nothing on screen to erase next frame
                    advance    = 1'b1;
                    shadow_clr = (phase_reg == DRAW);
                end
            end
            RUN: begin
                // The first RUN cycle may still see done from the previous
                // rectangle, so it is never allowed to complete
                if (!run_first_reg && drw.drw_done) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                advance   = 1'b1;
                shadow_wr = (phase_reg == DRAW);
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (advance) begin
            if (slot_reg == LAST_SLOT) begin
                if (phase_reg == ERASE) begin
                    phase_next = DRAW;
                    slot_next  = '0;
                    state_next = LOAD;
                end else begin
                    state_next      = IDLE;
                    busy_next       = 1'b0;
                    frame_done_next = 1'b1;
                end
            end else begin
                slot_next  = slot_reg + SLOT_W'(1);
                state_next = LOAD;
            end
        end
    end

    assign presenting   = ((state_reg == LOAD) && eligible) || (state_reg == RUN);

    assign drw.drw_load = (state_reg == LOAD) && eligible;
    assign drw.drw_go   = (state_reg == RUN);
    assign drw.plot     = drw.drw_go & ~drw.drw_done;
    assign drw.rx       = presenting ? src_x : 8'd0;
    assign drw.ry       = presenting ? src_y : 7'd0;
    assign drw.rw       = presenting ? src_w : 5'd0;
    assign drw.rh       = presenting ? src_h : 5'd0;
    assign drw.rc       = presenting ? src_c : 3'd0;

    assign busy         = busy_reg;
    assign frame_done   = frame_done_reg;
    assign overrun      = overrun_reg;

endmodule
